param_mc_core: RTL

- Parametrised multicycle successor to the 16-bit single-cycle core.
- Fetches fixed 16-bit instructions over a req/valid handshake and executes them in a FETCH/EXEC/WB state machine.
- Datapath width and PC width are parameters; the block adds N/Z/C flags, flag-conditioned branches, a halt instruction and a debug register read port.
- Sits between the instruction memory and the testbench/top; the ALU is a separate combinational sub-module.

---
 rtl/param_mc_core_pkg.sv | 14 +
 rtl/param_mc_core_alu.sv | 33 +++
 rtl/param_mc_core.sv | 97 +++++++++
 3 files changed

// File: rtl/param_mc_core_pkg.sv
// param_mc_core_pkg: shared state, opcode and instruction-field definitions for param_mc_core
package param_mc_core_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;
   typedef enum logic [1:0] {FMT_RR, FMT_RI, FMT_BR, FMT_HALT} fmt_t;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV} alu_op_t;
   typedef enum logic [1:0] {C_ALWAYS, C_Z, C_NZ, C_C} cond_t;
   localparam int FMT_LSB  = 0;
   localparam int COND_LSB = 2;
   localparam int SEL_LSB  = 2;
   localparam int TGT_LSB  = 4;
   localparam int IMM_LSB  = 5;
   localparam int RY_LSB   = 10;
   localparam int RX_LSB   = 13;
endpackage

// File: rtl/param_mc_core_alu.sv
// param_mc_alu: combinational ALU returning a DATA_W result plus carry/borrow
module param_mc_alu import param_mc_core_pkg::*; #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_t           op,
   output logic [DATA_W-1:0] res,
   output logic              carry
);
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] sh;
   assign sum = {1'b0, a} + {1'b0, b};
   assign sh  = b % DATA_W'(DATA_W);
   always_comb begin
      res   = '0;
      carry = 1'b0;
      case (op)
         OP_ADD: {carry, res} = sum;
         OP_SUB: begin
            res   = a - b;
            carry = a < b;
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_SHL: res = a << sh;
         OP_SHR: res = a >> sh;
         OP_MOV: res = b;
         default: res = '0;
      endcase
   end
endmodule

// File: rtl/param_mc_core.sv
// param_mc_core: parametrised multicycle FETCH/EXEC/WB core with flags, branches, halt and debug read
module param_mc_core import param_mc_core_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic              fetch_req,
   output logic [PC_W-1:0]   fetch_addr,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] d_out,
   output logic              done,
   output logic              halted,
   output logic [2:0]        flags,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);
   state_t            state, state_n;
   logic [PC_W-1:0]   pc, target;
   logic [15:0]       ir;
   logic [DATA_W-1:0] regs [8];
   logic [DATA_W-1:0] res_q, a, b, imm, alu_res;
   logic              alu_c, taken;
   logic [2:0]        rx, ry;
   fmt_t              fmt;
   cond_t             cond;
   alu_op_t           op;

   assign fmt    = fmt_t'(ir[FMT_LSB +: 2]);
   assign cond   = cond_t'(ir[COND_LSB +: 2]);
   assign op     = alu_op_t'(ir[SEL_LSB +: 3]);
   assign rx     = ir[RX_LSB +: 3];
   assign ry     = ir[RY_LSB +: 3];
   assign imm    = DATA_W'(ir[IMM_LSB +: 8]);
   assign target = ir[TGT_LSB +: PC_W];
   assign a      = regs[rx];
   assign b      = fmt == FMT_RI ? imm : regs[ry];
   assign taken  = cond == C_ALWAYS ? 1'b1 :
                   cond == C_Z      ? flags[1] :
                   cond == C_NZ     ? !flags[1] : flags[0];

   param_mc_alu #(.DATA_W(DATA_W)) u_alu (
      .a(a), .b(b), .op(op), .res(alu_res), .carry(alu_c)
   );

   assign fetch_req  = state == FETCH;
   assign done       = state == WB;
   assign halted     = state == HALT;
   assign fetch_addr = pc;
   assign dbg_data   = regs[dbg_sel];

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  state_n = run ? FETCH : IDLE;
         FETCH: state_n = instr_valid ? EXEC : FETCH;
         EXEC:  state_n = fmt == FMT_HALT ? HALT : fmt == FMT_BR ? (run ? FETCH : IDLE) : WB;
         WB:    state_n = run ? FETCH : IDLE;
         HALT:  state_n = HALT;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;

   // WB writes the register file on the closing edge, so a same-cycle debug read sees the old value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc    <= '0;
         ir    <= '0;
         res_q <= '0;
         d_out <= '0;
         flags <= '0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         case (state)
            FETCH: if (instr_valid) ir <= instr;
            EXEC: begin
               if (fmt == FMT_RR || fmt == FMT_RI) begin
                  res_q <= alu_res;
                  flags <= {alu_res[DATA_W-1], alu_res == '0, alu_c};
               end else if (fmt == FMT_BR) pc <= taken ? target : pc + 1'b1;
            end
            WB: begin
               regs[rx] <= res_q;
               d_out    <= res_q;
               pc       <= pc + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
